// File: rtl/io_supply_seq_pkg.sv
// Shared types and widths for the IO supply power-up sequencer.
package io_seq_pkg;

  localparam int CNT_W  = 8;
  localparam int WDOG_W = 16;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_DBNC    = 3'd1,
    ST_REL_RET = 3'd2,
    ST_EN_IE   = 3'd3,
    ST_ON      = 3'd4
  } io_seq_state_e;

  // Saturating increment: the debounce/settle counter must never wrap.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/io_supply_seq_if.sv
// Supply-detect inputs and pad-ring controls of the IO supply sequencer.
// master = sequencer side, slave = pad ring / SoC side.
interface io_supply_seq_if;

  logic       vddq_ok_i;
  logic       seq_en_i;
  logic       pad_ret_o;
  logic       pad_ie_en_o;
  logic       pad_oe_en_o;
  logic       ready_o;
  logic       fault_o;
  logic       timeout_o;
  logic [2:0] state_o;

  modport master (
    input  vddq_ok_i, seq_en_i,
    output pad_ret_o, pad_ie_en_o, pad_oe_en_o, ready_o, fault_o, timeout_o, state_o
  );

  modport slave (
    output vddq_ok_i, seq_en_i,
    input  pad_ret_o, pad_ie_en_o, pad_oe_en_o, ready_o, fault_o, timeout_o, state_o
  );

endinterface

// File: rtl/io_supply_seq_sync.sv
// Generic multi-flop synchronizer for asynchronous pad-domain flags.
// Synchronous active-low reset clears every stage to 0.
module io_seq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      // NOTE: non-blocking, so each stage captures its neighbour's previous value.
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/io_supply_seq.sv
// Power-up sequencer for the EG1.8V IO ring: debounce supply-good, then release
// retention, input enable and output enable in order. Optional DBNC watchdog: IO_SEQ_TIMEOUT_EN.
module io_supply_seq
  import io_seq_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int SETTLE_CYC   = 8,
  parameter int TIMEOUT_CYC  = 1024
) (
  input logic              clk,
  input logic              rst_n,
  io_supply_seq_if.master  io
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_chk_sync
    $error("io_supply_seq: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYC < 1 || DEBOUNCE_CYC > 255) begin : g_chk_dbnc
    $error("io_supply_seq: DEBOUNCE_CYC must be 1..255");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_chk_settle
    $error("io_supply_seq: SETTLE_CYC must be 1..255");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_chk_tmo
    $error("io_supply_seq: TIMEOUT_CYC must be 1..65535");
  end

  localparam logic [CNT_W-1:0] DBNC_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  io_seq_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             ret_q, ie_q, oe_q;
  logic             ok_s;

  io_seq_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (io.vddq_ok_i),
    .q     (ok_s)
  );

  // Pad controls are decoded from the next state so they switch on the same
  // edge as the state register and never glitch during teardown.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      ret_q   <= 1'b1;
      ie_q    <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      ret_q   <= (state_d == ST_OFF) || (state_d == ST_DBNC);
      ie_q    <= (state_d == ST_EN_IE) || (state_d == ST_ON);
      oe_q    <= (state_d == ST_ON);
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_sat_inc(cnt_q);
    fault_d = fault_q;
    unique case (state_q)
      ST_OFF: begin
        cnt_d = '0;
        if (io.seq_en_i) state_d = ST_DBNC;
      end
      ST_DBNC: begin
        if (!ok_s)                   cnt_d   = '0;
        else if (cnt_q == DBNC_LAST) state_d = ST_REL_RET;
      end
      ST_REL_RET: begin
        if (!ok_s) begin
          state_d = ST_DBNC;
          fault_d = 1'b1;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_EN_IE;
        end
      end
      ST_EN_IE: begin
        if (!ok_s) begin
          state_d = ST_DBNC;
          fault_d = 1'b1;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (!ok_s) begin
          state_d = ST_DBNC;
          fault_d = 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
    // Disable overrides any supply-drop handling and clears the sticky flags.
    if (!io.seq_en_i) begin
      state_d = ST_OFF;
      fault_d = 1'b0;
    end
    if (state_d != state_q) cnt_d = '0;
  end

`ifdef IO_SEQ_TIMEOUT_EN
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

  logic [WDOG_W-1:0] wdog_q;
  logic              timeout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == ST_DBNC && state_d == ST_DBNC)
        wdog_q <= (&wdog_q) ? wdog_q : wdog_q + 1'b1;
      else
        wdog_q <= '0;
      if (!io.seq_en_i)
        timeout_q <= 1'b0;
      else if (state_q == ST_DBNC && wdog_q == WDOG_LAST)
        timeout_q <= 1'b1;
    end
  end

  assign io.timeout_o = timeout_q;
`else
  assign io.timeout_o = 1'b0;
`endif

  assign io.pad_ret_o   = ret_q;
  assign io.pad_ie_en_o = ie_q;
  assign io.pad_oe_en_o = oe_q;
  assign io.ready_o     = oe_q;
  assign io.fault_o     = fault_q;
  assign io.state_o     = state_q;

endmodule

// File: tb/tb_io_supply_seq.sv
// Directed bench for io_supply_seq: power-up, bounce, drop, disable, reset and watchdog.
// Edge numbering in comments counts rising edges from the step that samples the stimulus.
module tb_io_supply_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  io_supply_seq_if bus ();

  io_supply_seq #(
    .SYNC_STAGES  (2),
    .DEBOUNCE_CYC (16),
    .SETTLE_CYC   (8),
    .TIMEOUT_CYC  (64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pads(input string tag, input logic ret, input logic ie,
                            input logic oe, input logic rdy, input logic flt,
                            input logic [2:0] st);
    check({tag, ".ret"},   8'(bus.pad_ret_o),   8'(ret));
    check({tag, ".ie"},    8'(bus.pad_ie_en_o), 8'(ie));
    check({tag, ".oe"},    8'(bus.pad_oe_en_o), 8'(oe));
    check({tag, ".ready"}, 8'(bus.ready_o),     8'(rdy));
    check({tag, ".fault"}, 8'(bus.fault_o),     8'(flt));
    check({tag, ".state"}, 8'(bus.state_o),     8'(st));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.seq_en_i  = 1'b0;
    bus.vddq_ok_i = 1'b0;
    repeat (3) step();
    check_pads("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    check("reset.timeout", 8'(bus.timeout_o), 8'd0);

    rst_n = 1'b1;
    step();
    check("idle_off.state", 8'(bus.state_o), 8'd0);
    bus.seq_en_i = 1'b1;
    step();
    check("enter_dbnc.state", 8'(bus.state_o), 8'd1);

    // Nominal: supply sampled high at E0 -> ret off after E17, ie after E25, oe/ready after E33.
    bus.vddq_ok_i = 1'b1;
    for (int e = 0; e <= 33; e++) begin
      step();
      if (e == 16) check_pads("nom_e16", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
      if (e == 17) check_pads("nom_e17", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
      if (e == 24) check_pads("nom_e24", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
      if (e == 25) check_pads("nom_e25", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
      if (e == 32) check_pads("nom_e32", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
      if (e == 33) check_pads("nom_e33", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4);
    end

    // Bounce: high B0..B9, low at B10, high from B11 -> release at B11+17 = B28.
    bus.seq_en_i  = 1'b0;
    bus.vddq_ok_i = 1'b0;
    step();
    check_pads("dis_from_on", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    bus.seq_en_i = 1'b1;
    repeat (3) step();
    for (int b = 0; b <= 28; b++) begin
      bus.vddq_ok_i = (b != 10);
      step();
      if (b == 17) check_pads("bnc_b17", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
      if (b == 27) check_pads("bnc_b27", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
      if (b == 28) check_pads("bnc_b28", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    end
    repeat (16) step();
    check_pads("bnc_on", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4);

    // Single-cycle drop in ON sampled at D: teardown after D+2, resequence to ON at D+34.
    bus.vddq_ok_i = 1'b0;
    step();
    bus.vddq_ok_i = 1'b1;
    check("drop_d0.ready", 8'(bus.ready_o), 8'd1);
    step();
    check_pads("drop_d1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4);
    step();
    check_pads("drop_d2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    for (int d = 3; d <= 34; d++) begin
      step();
      if (d == 17) check_pads("reseq_d17", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
      if (d == 18) check_pads("reseq_d18", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
      if (d == 33) check_pads("reseq_d33", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
      if (d == 34) check_pads("reseq_d34", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4);
    end

    // Disable clears fault; re-enable with supply already good reaches EN_IE at F+24.
    bus.seq_en_i = 1'b0;
    step();
    check_pads("dis_clr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    bus.seq_en_i = 1'b1;
    step();
    for (int f = 1; f <= 24; f++) begin
      step();
      if (f == 23) check("mid_f23.state", 8'(bus.state_o), 8'd2);
      if (f == 24) check("mid_f24.state", 8'(bus.state_o), 8'd3);
    end
    // Supply low sampled at G reaches the FSM at G+2, together with seq_en_i=0.
    bus.vddq_ok_i = 1'b0;
    step();
    check("mid_g0.state", 8'(bus.state_o), 8'd3);
    step();
    check_pads("mid_g1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3);
    bus.seq_en_i = 1'b0;
    step();
    check_pads("mid_dis", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Reach ON, take a drop to set fault, then reset for one edge.
    bus.vddq_ok_i = 1'b1;
    bus.seq_en_i  = 1'b1;
    for (int i = 0; i < 100 && !bus.ready_o; i++) step();
    check("rst_pre.ready", 8'(bus.ready_o), 8'd1);
    bus.vddq_ok_i = 1'b0;
    step();
    bus.vddq_ok_i = 1'b1;
    step();
    step();
    for (int i = 0; i < 100 && !bus.ready_o; i++) step();
    check_pads("rst_pre2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4);
    rst_n = 1'b0;
    step();
    check_pads("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    check("rst_mid.timeout", 8'(bus.timeout_o), 8'd0);
    rst_n = 1'b1;
    // Cleared synchronizer delays ok_s by one extra edge: release at R+18, not R+17.
    for (int r = 1; r <= 18; r++) begin
      step();
      if (r == 1)  check("rst_r1.state", 8'(bus.state_o), 8'd1);
      if (r == 17) check_pads("rst_r17", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
      if (r == 18) check_pads("rst_r18", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    end

    // Watchdog: 64 DBNC cycles with no supply.
    bus.seq_en_i  = 1'b0;
    bus.vddq_ok_i = 1'b0;
    step();
    bus.seq_en_i = 1'b1;
    step();
`ifdef IO_SEQ_TIMEOUT_EN
    for (int t = 1; t <= 64; t++) begin
      step();
      if (t == 63) check("wd_t63.timeout", 8'(bus.timeout_o), 8'd0);
      if (t == 64) check("wd_t64.timeout", 8'(bus.timeout_o), 8'd1);
    end
    check("wd_t64.state", 8'(bus.state_o), 8'd1);
    bus.vddq_ok_i = 1'b1;
    for (int i = 0; i < 100 && !bus.ready_o; i++) step();
    check("wd_on.ready", 8'(bus.ready_o), 8'd1);
    check("wd_on.timeout", 8'(bus.timeout_o), 8'd1);
    bus.seq_en_i = 1'b0;
    step();
    check("wd_dis.timeout", 8'(bus.timeout_o), 8'd0);
`else
    repeat (70) step();
    check("nowd.timeout", 8'(bus.timeout_o), 8'd0);
    check("nowd.state", 8'(bus.state_o), 8'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_supply_seq.md
Name: io_supply_seq

Overview:
Digital-side power-up sequencer for the GF22FDX EG1.8V IO ring. It consumes the asynchronous "IO supply good" indication that comes from the VDDQ/VSSQ supply pads of the IO domain. It debounces that indication, then releases pad retention, input enable and output enable in a fixed order with settle delays. It tears all of them down in one step when the supply drops or sequencing is disabled, and it sits in the always-on core domain next to the pad ring.

Parameters:
SYNC_STAGES, 2, flops in the vddq_ok_i synchronizer (legal range 2..4)
DEBOUNCE_CYC, 16, consecutive synchronized-high cycles required before release (legal range 1..255)
SETTLE_CYC, 8, cycles spent in each of REL_RET and EN_IE (legal range 1..255)
TIMEOUT_CYC, 1024, DBNC watchdog limit in cycles; used only with IO_SEQ_TIMEOUT_EN (legal range 1..65535)

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
vddq_ok_i  in  1  asynchronous IO supply-good flag from the VDDQ domain detector
seq_en_i  in  1  software/boot enable for sequencing; level-sensitive
pad_ret_o  out  1  pad retention hold (1 = held)
pad_ie_en_o  out  1  global pad input enable
pad_oe_en_o  out  1  global pad output enable
ready_o  out  1  IO ring fully operational
fault_o  out  1  sticky flag: supply dropped after retention release
timeout_o  out  1  sticky DBNC watchdog flag; tied 0 without IO_SEQ_TIMEOUT_EN
state_o  out  3  current FSM state encoding, for debug

Behaviour:
- Single clock domain. Reset is synchronous and active-low; ports are clk and rst_n.
- Reset values: pad_ret_o=1, pad_ie_en_o=0, pad_oe_en_o=0, ready_o=0, fault_o=0, timeout_o=0, state=OFF, all counters=0, synchronizer flops=0.
- Synchronizer: vddq_ok_i passes through SYNC_STAGES flops to give ok_s. A level sampled at edge E appears on ok_s after edge E+SYNC_STAGES-1.
- FSM states and encodings: OFF=0, DBNC=1, REL_RET=2, EN_IE=3, ON=4.
- OFF -> DBNC when seq_en_i=1.
- DBNC:
  - cnt increments each cycle while ok_s=1 and clears to 0 when ok_s=0.
  - When ok_s=1 and cnt==DEBOUNCE_CYC-1, go to REL_RET.
- REL_RET: go to EN_IE after exactly SETTLE_CYC cycles in the state. ok_s=0 goes to DBNC and sets fault_o.
- EN_IE: go to ON after exactly SETTLE_CYC cycles in the state. ok_s=0 goes to DBNC and sets fault_o.
- ON: holds. ok_s=0 goes to DBNC and sets fault_o.
- seq_en_i=0 in any state: next state is OFF. This has priority over the ok_s drop. fault_o and timeout_o clear on that same edge.
- cnt clears on every state change. cnt saturates and never wraps.
- Outputs are flops loaded from the next-state decode, so each pad control changes on the same edge as the state register:
  - pad_ret_o=1 in OFF and DBNC
  - pad_ie_en_o=1 in EN_IE and ON
  - pad_oe_en_o=1 and ready_o=1 in ON only
- Teardown from ON on either seq_en_i=0 or ok_s=0 removes oe, ie and ready and asserts ret, all on one edge. There are no intermediate combinational glitches.
- A supply drop sets fault_o even if it lasts a single synchronized cycle.

Optional Feature:
- Macro: IO_SEQ_TIMEOUT_EN.
- Enabled: a 16-bit watchdog counts every cycle in DBNC and clears on leaving DBNC.
  - On reaching TIMEOUT_CYC-1 it sets timeout_o, which is sticky.
  - The FSM stays in DBNC and can still complete the sequence.
  - timeout_o clears only on reset or seq_en_i=0.
- Disabled: no watchdog logic is present and timeout_o is constant 0.

Decomposition:
- Package io_seq_pkg holds:
  - typedef enum logic [2:0] io_seq_state_e with the encodings above
  - localparam CNT_W=8
  - localparam WDOG_W=16
- Sub-module io_seq_sync: generic SYNC_STAGES flop synchronizer with synchronous active-low reset to 0. It is reused for other asynchronous pad-domain flags.

Test Plan:
- Nominal power-up:
  - Stimulus: rst_n released, seq_en_i=1, vddq_ok_i rises sampled at edge E0, defaults.
  - Response: pad_ret_o falls after E17, pad_ie_en_o rises after E25, pad_oe_en_o and ready_o rise after E33, fault_o=0.
- Bouncing supply:
  - Stimulus: vddq_ok_i high 10 cycles, low 1 cycle, then high.
  - Response: debounce restarts, ret released exactly 16 ok_s-high cycles after the last low, fault_o stays 0.
- Drop in ON:
  - Stimulus: vddq_ok_i=0 for 1 cycle while ready_o=1.
  - Response: 2 edges later (sync) oe=0, ie=0, ret=1, ready_o=0 and fault_o=1 together, state_o=1. Re-sequence to ON completes with fault_o still 1.
- Disable mid-sequence:
  - Stimulus: seq_en_i=0 during EN_IE.
  - Response: next edge state_o=0, ie=0, ret=1. Same-cycle ok drop gives fault_o=0 because disable has priority.
- Reset mid-operation:
  - Stimulus: rst_n=0 for 1 edge while in ON.
  - Response: all outputs at reset values after that edge, and synchronizer cleared.
- IO_SEQ_TIMEOUT_EN:
  - Stimulus: TIMEOUT_CYC=64, seq_en_i=1, vddq_ok_i=0.
  - Response: timeout_o=1 after 64 DBNC cycles. Supply later rises and the sequence completes with timeout_o still 1. Without the macro, timeout_o is always 0.
